// File: rtl/sa_skew_feeder_pkg.sv
// -----------------------------------------------------------------------------
// sa_skew_feeder_pkg
// Shared definitions for the systolic-array skew feeder:
//   SA_DW     default lane width (bits) of PE data and weights
//   state_e   feeder FSM encoding (IDLE=0, STREAM=1, FLUSH=2, DONE=3)
//   lane_lo   low bit index of lane 'lane' inside a packed N*DW vector
// -----------------------------------------------------------------------------
package sa_skew_feeder_pkg;

   localparam int unsigned SA_DW = 32'd8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_FLUSH  = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   // Lane i of a packed vector occupies bits [lane_lo(i, dw) +: dw].
   function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned dw);
      return lane * dw;
   endfunction

endpackage

// File: rtl/sa_skew_feeder_skew_line.sv
// -----------------------------------------------------------------------------
// skew_line
// Resettable DW-wide shift chain of DEPTH registers. A value presented on d
// before edge t is visible on q after edge t+DEPTH-1.
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset, clears every stage to 0
//   d    chain input (DW bits)
//   q    output of the last stage (DW bits)
// -----------------------------------------------------------------------------
module skew_line
   import sa_skew_feeder_pkg::*;
#(
   parameter int unsigned DW    = SA_DW,
   parameter int unsigned DEPTH = 32'd1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] d,
   output logic [DW-1:0] q
);

   logic [DW-1:0] stage_r [DEPTH];

   // Shift chain: stage 0 loads d, every later stage loads its predecessor.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < int'(DEPTH); k++) begin
            stage_r[k] <= {DW{1'b0}};
         end
      end else begin
         stage_r[0] <= d;
         for (int k = 1; k < int'(DEPTH); k++) begin
            stage_r[k] <= stage_r[k-1];
         end
      end
   end

   assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/sa_skew_feeder.sv
// -----------------------------------------------------------------------------
// sa_skew_feeder
// Upstream feeder for an N x N systolic array. Accepts one activation vector
// and one weight vector per handshake, delays lane i by i extra cycles (the
// diagonal skew the grid needs) and sequences one tile of LEN vectors:
// stream, flush the skew with zeros, then pulse done.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   start      begin a tile (only honoured in IDLE)
//   len        tile length in vectors, captured with start
//   in_valid   in_data/in_wt carry a valid vector pair
//   in_ready   feeder accepts a vector this cycle (STREAM)
//   in_data    activation vector, lane i at [i*DW +: DW]
//   in_wt      weight vector, same packing
//   l_out      skewed activations to the array left edge (row i)
//   u_out      skewed weights to the array top edge (column i)
//   pe_clr     one-cycle pulse on the start cycle, clears PE accumulators
//   busy       high while streaming or flushing
//   done       one-cycle pulse once the tile has fully left the feeder
// -----------------------------------------------------------------------------
module sa_skew_feeder
   import sa_skew_feeder_pkg::*;
#(
   parameter int unsigned N  = 32'd4,
   parameter int unsigned DW = SA_DW,
   parameter int unsigned LW = 32'd8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [LW-1:0]   len,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N*DW-1:0] in_data,
   input  logic [N*DW-1:0] in_wt,
   output logic [N*DW-1:0] l_out,
   output logic [N*DW-1:0] u_out,
   output logic            pe_clr,
   output logic            busy,
   output logic            done
);

   // Flush counter covers 0..N-1.
   localparam int unsigned    FW         = $clog2(N + 32'd1);
   localparam logic [FW-1:0]  FLUSH_LAST = FW'(N - 32'd1);

   state_e            state_r;
   state_e            next_s;
   logic [LW-1:0]     cnt_r;
   logic [LW-1:0]     len_r;
   logic [FW-1:0]     fcnt_r;
   logic              in_ready_r;
   logic              busy_r;
   logic              done_r;
   logic              accept_s;
   logic              last_accept_s;
   logic              pe_clr_s;
   logic [N*DW-1:0]   stage0_data_s;
   logic [N*DW-1:0]   stage0_wt_s;

   // in_ready_r mirrors "state is STREAM", so this is the handshake itself.
   assign accept_s      = in_valid & in_ready_r;
   assign last_accept_s = accept_s & (cnt_r == (len_r - LW'(1'b1)));

   // pe_clr must coincide with the start cycle, so it is decoded from start.
   assign pe_clr_s = (state_r == ST_IDLE) & start;

   // Next-state logic for the tile sequencer.
   always_comb begin
      next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               if (len == {LW{1'b0}}) begin
                  next_s = ST_DONE;
               end else begin
                  next_s = ST_STREAM;
               end
            end else begin
               next_s = ST_IDLE;
            end
         end
         ST_STREAM: begin
            if (last_accept_s) begin
               next_s = ST_FLUSH;
            end else begin
               next_s = ST_STREAM;
            end
         end
         // Flush holds N cycles so that done lands in the cycle after the
         // deepest lane has emitted its last element.
         ST_FLUSH: begin
            if (fcnt_r == FLUSH_LAST) begin
               next_s = ST_DONE;
            end else begin
               next_s = ST_FLUSH;
            end
         end
         ST_DONE: begin
            next_s = ST_IDLE;
         end
         default: begin
            next_s = ST_IDLE;
         end
      endcase
   end

   // State register plus status outputs registered from the next state, so
   // each status bit is glitch-free and aligned with the state it reports.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         in_ready_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r    <= next_s;
         in_ready_r <= (next_s == ST_STREAM);
         busy_r     <= (next_s == ST_STREAM) || (next_s == ST_FLUSH);
         done_r     <= (next_s == ST_DONE);
      end
   end

   // Tile length capture, vector counter and flush counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r  <= {LW{1'b0}};
         len_r  <= {LW{1'b0}};
         fcnt_r <= {FW{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               fcnt_r <= {FW{1'b0}};
               if (start) begin
                  len_r <= len;
                  cnt_r <= {LW{1'b0}};
               end
            end
            ST_STREAM: begin
               fcnt_r <= {FW{1'b0}};
               if (accept_s) begin
                  cnt_r <= cnt_r + LW'(1'b1);
               end
            end
            ST_FLUSH: begin
               fcnt_r <= fcnt_r + FW'(1'b1);
            end
            default: begin
               fcnt_r <= {FW{1'b0}};
            end
         endcase
      end
   end

   // Stage-0 value: the accepted vector, or a zero bubble on every other cycle.
   always_comb begin
      stage0_data_s = {(N*DW){1'b0}};
      stage0_wt_s   = {(N*DW){1'b0}};
      if (accept_s) begin
         stage0_data_s = in_data;
         stage0_wt_s   = in_wt;
      end else begin
         stage0_data_s = {(N*DW){1'b0}};
         stage0_wt_s   = {(N*DW){1'b0}};
      end
   end

   // Lane i gets a chain of depth i+1; data and weight lanes share latency.
   for (genvar i = 0; i < int'(N); i++) begin : g_lane
      localparam int unsigned LO = lane_lo(i, DW);

      skew_line #(
         .DW    (DW),
         .DEPTH (i + 1)
      ) u_data_line (
         .clk (clk),
         .rst (rst),
         .d   (stage0_data_s[LO +: DW]),
         .q   (l_out[LO +: DW])
      );

      skew_line #(
         .DW    (DW),
         .DEPTH (i + 1)
      ) u_wt_line (
         .clk (clk),
         .rst (rst),
         .d   (stage0_wt_s[LO +: DW]),
         .q   (u_out[LO +: DW])
      );
   end

   assign in_ready = in_ready_r;
   assign busy     = busy_r;
   assign done     = done_r;
   assign pe_clr   = pe_clr_s;

endmodule
